// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: drives IMemory from the PC register and queues {pc, instr}
// pairs in a 2-entry buffer that decode drains through a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic        r_misalign;

  logic        w_pop;
  logic        w_fire;
  logic        w_tail;
  logic        w_aligned;

  assign w_pop     = (r_count != 2'd0) & id_ready;
  assign w_fire    = (r_state == S_RUN) & fetch_en & ~redirect_valid &
                     ((r_count < 2'd2) | w_pop);
  // head+count mod 2; at count=2 this is the slot being popped this cycle
  assign w_tail    = r_head ^ r_count[0];
  assign w_aligned = (redirect_pc[1:0] == 2'b00);

  assign imem_addr    = r_pc;
  assign id_valid     = (r_count != 2'd0);
  assign id_instr     = r_buf_instr[r_head];
  assign id_pc        = r_buf_pc[r_head];
  assign misalign_err = r_misalign;

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      if (w_aligned) w_state_nxt = fetch_en ? S_RUN : S_IDLE;
      else           w_state_nxt = S_ERR;
    end else begin
      case (r_state)
        S_IDLE:  if (fetch_en)  w_state_nxt = S_RUN;
        S_RUN:   if (!fetch_en) w_state_nxt = S_IDLE;
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc       <= {redirect_pc[31:2], 2'b00};
        r_misalign <= ~w_aligned;
        r_head     <= 1'b0;
        r_count    <= 2'd0;
      end else begin
        if (w_fire) r_pc <= r_pc + 32'd4;
        r_head  <= r_head ^ w_pop;
        r_count <= r_count + {1'b0, w_fire} - {1'b0, w_pop};
      end
    end
  end

  // Data slots are cleared on reset so id_instr/id_pc read zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_pc[0]    <= 32'd0;
      r_buf_pc[1]    <= 32'd0;
      r_buf_instr[0] <= 32'd0;
      r_buf_instr[1] <= 32'd0;
    end else if (w_fire) begin
      r_buf_pc[w_tail]    <= r_pc;
      r_buf_instr[w_tail] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference of the fetch buffer.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, id_instr, id_pc;
  logic        id_valid, misalign_err;

  always #5 clk = ~clk;

  // IMemory: word k holds value k
  assign imem_instr = imem_addr >> 2;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .misalign_err(misalign_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_err;
  bit          m_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic rs, input logic fe, input logic rdy,
                     input logic rv, input logic [31:0] rpc);
    bit pop, fire;
    @(negedge clk);
    if (m_known) begin
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("id_valid", {31'd0, id_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
      check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
      if (m_q.size() != 0) begin
        check_eq("id_pc", id_pc, m_q[0][63:32]);
        check_eq("id_instr", id_instr, m_q[0][31:0]);
      end
    end
    rst = rs; fetch_en = fe; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (rs) begin
      m_q.delete(); m_pc = RST_PC; m_mode = M_IDLE; m_err = 1'b0; m_known = 1'b1;
    end else begin
      pop = (m_q.size() != 0) && rdy;
      if (rv) begin
        m_q.delete();
        if (rpc[1:0] == 2'b00) begin
          m_pc = rpc; m_err = 1'b0; m_mode = fe ? M_RUN : M_IDLE;
        end else begin
          m_pc = {rpc[31:2], 2'b00}; m_err = 1'b1; m_mode = M_ERR;
        end
      end else begin
        fire = (m_mode == M_RUN) && fe && (m_q.size() < 2 || pop);
        if (pop) void'(m_q.pop_front());
        if (fire) begin
          m_q.push_back({m_pc, m_pc >> 2});
          m_pc = m_pc + 32'd4;
        end
        if (m_mode == M_IDLE && fe) m_mode = M_RUN;
        else if (m_mode == M_RUN && !fe) m_mode = M_IDLE;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b0; fetch_en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    // 1: reset, then streaming fetch
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    #1;
    check_eq("rst_addr", imem_addr, RST_PC);
    check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("rst_instr", id_instr, 32'd0);
    check_eq("rst_pc", id_pc, 32'd0);
    check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);
    repeat (8) cyc(0, 1, 1, 0, 0);

    // 2: stall until full, then release
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 0);
    #1;
    check_eq("stall_addr", imem_addr, 32'h8);
    check_eq("stall_pc", id_pc, 32'h0);
    check_eq("stall_valid", {31'd0, id_valid}, 32'd1);
    repeat (6) cyc(0, 1, 1, 0, 0);

    // 3: redirect while full
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h40);
    #1;
    check_eq("redir_valid", {31'd0, id_valid}, 32'd0);
    check_eq("redir_addr", imem_addr, 32'h40);
    cyc(0, 1, 1, 0, 0);
    #1 check_eq("redir_pc0", id_pc, 32'h40);
    cyc(0, 1, 1, 0, 0);
    #1 check_eq("redir_pc1", id_pc, 32'h44);
    repeat (2) cyc(0, 1, 1, 0, 0);

    // 4: misaligned redirect, then recovery
    cyc(0, 1, 1, 1, 32'h42);
    #1;
    check_eq("mis_err", {31'd0, misalign_err}, 32'd1);
    check_eq("mis_valid", {31'd0, id_valid}, 32'd0);
    check_eq("mis_addr", imem_addr, 32'h40);
    repeat (3) cyc(0, 1, 1, 0, 0);
    #1 check_eq("err_hold_addr", imem_addr, 32'h40);
    cyc(0, 1, 1, 1, 32'h80);
    #1 check_eq("recover_err", {31'd0, misalign_err}, 32'd0);
    cyc(0, 1, 1, 0, 0);
    #1 check_eq("recover_pc", id_pc, 32'h80);
    repeat (2) cyc(0, 1, 1, 0, 0);

    // 5: PC wrap
    cyc(0, 1, 1, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 1, 0, 0);
    #1;
    check_eq("wrap_addr", imem_addr, 32'h0);
    check_eq("wrap_pc_top", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap_instr", id_instr, 32'h3FFF_FFFF);
    cyc(0, 1, 1, 0, 0);
    #1 check_eq("wrap_pc_zero", id_pc, 32'h0);

    // 6: reset mid-stream with full buffer
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    #1;
    check_eq("midrst_valid", {31'd0, id_valid}, 32'd0);
    check_eq("midrst_addr", imem_addr, RST_PC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 24) == 0),
          rpc);
    end
    cyc(0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
